// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers (MULT, MULTU, DIV, DIVU).
// Define MDU_EARLY_OUT_EN to let multiplies finish once the remaining multiplier bits are zero.
module mul_div_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] OperandA,
    input  logic [31:0] OperandB,
    input  logic        HiWE,
    input  logic        LoWE,
    input  logic [31:0] HiLoData,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StFin} state_e;

    state_e      r_state;
    state_e      w_state_d;

    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic        r_div0;
    logic [63:0] r_mcand;
    logic [31:0] r_mplr;
    logic [63:0] r_acc;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_start;
    logic        w_last;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [63:0] w_mul_acc;
    logic [32:0] w_div_sh;
    logic [31:0] w_div_diff;
    logic        w_div_ge;
    logic [63:0] w_div_acc;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_signed = ~Op[0];
    assign w_a_neg  = w_signed & OperandA[31];
    assign w_b_neg  = w_signed & OperandB[31];
    assign w_a_mag  = w_a_neg ? (32'd0 - OperandA) : OperandA;
    assign w_b_mag  = w_b_neg ? (32'd0 - OperandB) : OperandB;

    assign w_start  = Start && ((r_state == StIdle) || (r_state == StFin));

`ifdef MDU_EARLY_OUT_EN
    // Multiply stops once no set multiplier bits remain after this step.
    assign w_last = (r_cnt == 5'd31) || (!r_is_div && (r_mplr[31:1] == 31'd0));
`else
    assign w_last = (r_cnt == 5'd31);
`endif

    // Multiply step: accumulate the shifted multiplicand when the multiplier LSB is set.
    assign w_mul_acc = r_acc + (r_mplr[0] ? r_mcand : 64'd0);

    // Restoring divide step: r_acc holds {remainder, dividend/quotient}.
    assign w_div_sh   = r_acc[63:31];
    assign w_div_ge   = (w_div_sh >= {1'b0, r_mplr});
    assign w_div_diff = w_div_sh[31:0] - r_mplr;
    assign w_div_acc  = w_div_ge ? {w_div_diff, r_acc[30:0], 1'b1}
                                 : {w_div_sh[31:0], r_acc[30:0], 1'b0};

    assign w_prod = r_neg_res ? (64'd0 - r_acc) : r_acc;
    assign w_quot = r_div0 ? 32'hFFFF_FFFF
                           : (r_neg_res ? (32'd0 - r_acc[31:0]) : r_acc[31:0]);
    assign w_rem  = r_neg_rem ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        Busy      = 1'b0;
        Done      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (Start) begin
                    w_state_d = StCalc;
                end
            end
            StCalc: begin
                Busy = 1'b1;
                if (w_last) begin
                    w_state_d = StFix;
                end
            end
            StFix: begin
                Busy      = 1'b1;
                w_state_d = StFin;
            end
            StFin: begin
                Done      = 1'b1;
                w_state_d = Start ? StCalc : StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt     <= 5'd0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_mcand   <= 64'd0;
            r_mplr    <= 32'd0;
            r_acc     <= 64'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            if (w_start) begin
                r_cnt     <= 5'd0;
                r_is_div  <= Op[1];
                r_neg_res <= w_a_neg ^ w_b_neg;
                r_neg_rem <= w_a_neg;
                r_div0    <= (OperandB == 32'd0);
                r_mcand   <= {32'd0, w_a_mag};
                r_mplr    <= w_b_mag;
                r_acc     <= Op[1] ? {32'd0, w_a_mag} : 64'd0;
            end else if (r_state == StCalc) begin
                r_cnt <= r_cnt + 5'd1;
                if (r_is_div) begin
                    r_acc <= w_div_acc;
                end else begin
                    r_acc   <= w_mul_acc;
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= r_mplr >> 1;
                end
            end

            // Start takes priority over MTHI/MTLO; nothing is written while busy.
            if (r_state == StFix) begin
                r_hi <= r_is_div ? w_rem : w_prod[63:32];
                r_lo <= r_is_div ? w_quot : w_prod[31:0];
            end else if (!Busy && !Start) begin
                if (HiWE) begin
                    r_hi <= HiLoData;
                end
                if (LoWE) begin
                    r_lo <= HiLoData;
                end
            end
        end
    end

    assign Hi = r_hi;
    assign Lo = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random ops vs an arithmetic model.
// Latency expectations follow MDU_EARLY_OUT_EN when it is defined for the build.
module tb_mul_div_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'd0;
    logic [31:0] OperandA = 32'd0;
    logic [31:0] OperandB = 32'd0;
    logic        HiWE = 1'b0;
    logic        LoWE = 1'b0;
    logic [31:0] HiLoData = 32'd0;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int n_total = 0;
    int n_bad   = 0;

    mul_div_unit u_dut (
        .CLK      (CLK),
        .RST      (RST),
        .Start    (Start),
        .Op       (Op),
        .OperandA (OperandA),
        .OperandB (OperandB),
        .HiWE     (HiWE),
        .LoWE     (LoWE),
        .HiLoData (HiLoData),
        .Busy     (Busy),
        .Done     (Done),
        .Hi       (Hi),
        .Lo       (Lo)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference results from plain 64-bit arithmetic.
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] hi,
                                      output logic [31:0] lo);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            2'd0: begin
                q  = sa * sb;
                hi = q[63:32];
                lo = q[31:0];
            end
            2'd1: begin
                p  = ua * ub;
                hi = p[63:32];
                lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else if (op == 2'd2) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    hi = r[31:0];
                    lo = q[31:0];
                end else begin
                    p  = ua / ub;
                    lo = p[31:0];
                    p  = ua % ub;
                    hi = p[31:0];
                end
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [1:0] op, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
        longint          sb;
        longint unsigned m;
        int              steps;
        if (op[1]) return 34;
        sb = longint'($signed(b));
        m  = (!op[0] && sb < 0) ? longint'(-sb) : {32'd0, b};
        steps = 0;
        while (m != 0) begin
            m = m >> 1;
            steps++;
        end
        if (steps < 1) steps = 1;
        return steps + 2;
`else
        return (op == 2'd0 && b == 32'd0) ? 34 : 34;
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called at posedge+1; drives Start immediately so back-to-back issue from FIN is exercised.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] eh, el, h0, l0;
        int          cyc;
        bit          held;
        ref_model(op, a, b, eh, el);
        Op       = op;
        OperandA = a;
        OperandB = b;
        Start    = 1'b1;
        h0       = Hi;
        l0       = Lo;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        HiWE  = 1'b0;
        LoWE  = 1'b0;
        cyc   = 1;
        held  = 1'b1;
        chk({tag, "_pre"}, {Hi, Lo}, {h0, l0});
        chk({tag, "_busy"}, 64'(Busy), 64'd1);
        while (!Done && cyc < 60) begin
            if (Hi !== h0 || Lo !== l0) held = 1'b0;
            if (cyc == 5 && Busy) begin
                Start    = 1'b1;
                HiWE     = 1'b1;
                LoWE     = 1'b1;
                HiLoData = $urandom;
                OperandA = $urandom;
                OperandB = $urandom;
                Op       = 2'($urandom_range(0, 3));
            end
            if (cyc == 6) begin
                Start = 1'b0;
                HiWE  = 1'b0;
                LoWE  = 1'b0;
            end
            @(posedge CLK);
            #1;
            cyc++;
        end
        Start = 1'b0;
        HiWE  = 1'b0;
        LoWE  = 1'b0;
        chk({tag, "_done"}, 64'(Done), 64'd1);
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_latency(op, b)));
        chk({tag, "_hold"}, 64'(held), 64'd1);
        chk({tag, "_hi"}, 64'(Hi), 64'(eh));
        chk({tag, "_lo"}, 64'(Lo), 64'(el));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] h_before;
        int          n_done;

        #1;
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_hilo", {Hi, Lo}, 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Start accepted at the first edge after reset release.
        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max_hi_k", 64'(Hi), 64'hFFFF_FFFE);
        chk("multu_max_lo_k", 64'(Lo), 64'h0000_0001);
        run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7);
        chk("mult_neg_k", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg_k", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_zero", 2'd3, 32'd5, 32'd0);
        chk("divu_zero_k", {Hi, Lo}, 64'h0000_0005_FFFF_FFFF);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_k", {Hi, Lo}, 64'h0000_0000_8000_0000);
        run_op("div_zero_neg", 2'd2, 32'hFFFF_FFF0, 32'd0);
        run_op("multu_small", 2'd1, 32'd3, 32'd2);
        chk("multu_small_k", {Hi, Lo}, 64'd6);

        // Done is a single-cycle pulse.
        @(posedge CLK);
        #1;
        chk("done_pulse", 64'(Done), 64'd0);

        // Idle MTHI/MTLO, then Start with LoWE in the same cycle.
        HiWE     = 1'b1;
        LoWE     = 1'b1;
        HiLoData = 32'h1234_5678;
        @(posedge CLK);
        #1;
        HiWE = 1'b0;
        LoWE = 1'b0;
        chk("mt_hi", 64'(Hi), 64'h1234_5678);
        chk("mt_lo", 64'(Lo), 64'h1234_5678);
        LoWE     = 1'b1;
        HiLoData = 32'h0000_DEAD;
        run_op("start_vs_mtlo", 2'd1, 32'd2, 32'd3);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                HiWE     = 1'($urandom_range(0, 1));
                LoWE     = 1'($urandom_range(0, 1));
                HiLoData = $urandom;
            end
            run_op($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), pick(), pick());
        end

        // Reset aborts an in-flight op; busy-time Start/HiWE are ignored.
        Op       = 2'd1;
        OperandA = 32'd2;
        OperandB = 32'd3;
        Start    = 1'b1;
        @(posedge CLK);
        #1;
        Start    = 1'b0;
        h_before = Hi;
        repeat (4) @(posedge CLK);
        #1;
        Start    = 1'b1;
        HiWE     = 1'b1;
        HiLoData = 32'h0000_AAAA;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        HiWE  = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        chk("abort_busy", 64'(Busy), 64'd1);
        chk("abort_hi_kept", 64'(Hi), 64'(h_before));
        RST = 1'b1;
        #1;
        chk("abort_rst_busy", 64'(Busy), 64'd0);
        chk("abort_rst_done", 64'(Done), 64'd0);
        chk("abort_rst_hilo", {Hi, Lo}, 64'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST    = 1'b0;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK);
            #1;
            if (Done) n_done++;
        end
        chk("abort_no_done", 64'(n_done), 64'd0);
        chk("abort_idle", 64'(Busy), 64'd0);
        run_op("after_abort", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 SHALL provide CLK  input  1  single clock; all state updates on posedge CLK.
REQ-003 SHALL provide RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide Start  input  1  request to begin an operation; accepted only when not Busy.
REQ-005 SHALL provide Op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL provide OperandA  input  32  rs value (multiplicand / dividend), driven from register file ReadData1.
REQ-007 SHALL provide OperandB  input  32  rt value (multiplier / divisor), driven from register file ReadData2.
REQ-008 SHALL provide HiWE  input  1  MTHI write enable.
REQ-009 SHALL provide LoWE  input  1  MTLO write enable.
REQ-010 SHALL provide HiLoData  input  32  data for MTHI/MTLO.
REQ-011 SHALL provide Busy  output  1  operation in progress.
REQ-012 SHALL provide Done  output  1  one-cycle completion pulse.
REQ-013 SHALL provide Hi  output  32  HI register (high product / remainder).
REQ-014 SHALL provide Lo  output  32  LO register (low product / quotient).

Function
REQ-015 SHALL implement states IDLE, CALC, FIX, FIN; Busy=1 in CALC and FIX only; Done=1 in FIN only.
REQ-016 SHALL, on a posedge in IDLE or FIN with Start=1, capture Op/OperandA/OperandB (as magnitudes plus sign flags for signed ops), clear the iteration counter, and enter CALC.
REQ-017 SHALL perform one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per CALC cycle; exactly 32 steps, then enter FIX.
REQ-018 SHALL, in FIX, apply sign correction (product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign), write Hi/Lo at the FIX->FIN edge, and enter FIN.
REQ-019 SHALL return from FIN to IDLE at the next edge unless Start=1 (back-to-back start accepted).
REQ-020 SHALL give fixed latency: Start sampled at edge 0 -> Busy high for cycles 1..33 -> Done high in cycle 34 with the new Hi/Lo visible in that cycle.
REQ-021 SHALL ignore Start, HiWE and LoWE while Busy; the in-flight result is not disturbed.
REQ-022 SHALL, when not Busy and Start=0, write HiLoData to Hi on HiWE and/or to Lo on LoWE at the posedge; if Start=1 in the same cycle, Start wins and HiWE/LoWE are ignored.
REQ-023 SHALL, on divide by zero (OperandB=0), complete with normal latency giving Hi=OperandA, Lo=0xFFFFFFFF.
REQ-024 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, give Lo=0x80000000, Hi=0x00000000 (no trap).
REQ-025 SHALL hold Hi/Lo unchanged between writes; outputs do not change during CALC/FIX.

Reset
REQ-026 SHALL, while RST=1, force state IDLE, Busy=0, Done=0, Hi=0, Lo=0, counter=0, independent of CLK.
REQ-027 SHALL abort any in-flight operation on reset, with no Done pulse and no partial Hi/Lo update.
REQ-028 SHALL accept Start at the first posedge after RST deasserts.

Configuration
REQ-029 SHALL, with MDU_EARLY_OUT_EN defined, end CALC for MULT/MULTU once the remaining multiplier shift register is zero (minimum 1 CALC cycle), shortening latency accordingly; DIV/DIVU remain at 32 steps.
REQ-030 SHALL, without MDU_EARLY_OUT_EN, use the fixed 32-step CALC for all operations; results are identical in both builds.

Verification
REQ-031 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001, Done in cycle 34 after Start.
REQ-032 SHALL cover: MULT 0xFFFFFFFD (-3) x 7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; DIV 0xFFFFFFF9 (-7) / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
REQ-033 SHALL cover: DIVU 5 / 0 -> Hi=0x00000005, Lo=0xFFFFFFFF; DIV 0x80000000 / -1 -> Lo=0x80000000, Hi=0.
REQ-034 SHALL cover: Start MULTU 2x3, pulse Start and HiWE (HiLoData=0xAAAA) in cycle 5, RST=1 in cycle 10 -> no effect from the cycle-5 pulses; after reset Busy=0, Done=0, Hi=Lo=0, and Done never pulses.
REQ-035 SHALL cover: idle HiWE=1, LoWE=1, HiLoData=0x12345678 -> Hi=Lo=0x12345678; then Start and LoWE in the same cycle -> LoWE ignored.
REQ-036 SHALL cover: with MDU_EARLY_OUT_EN, MULTU 3 x 2 -> Lo=6, Hi=0, Done in cycle 5 or earlier; without the macro, Done in cycle 34.
